// File: rtl/fip_pkg.sv
// Shared types and helpers for the fixed-point sequential divider.
// Saturation constants are computed at 64 bits and sliced by the user.
package fip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fip_div_state_t;

  function automatic logic [63:0] fip_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fip_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fip_udiv_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// The start cycle already performs the first step, so done pulses N cycles after start.
module fip_udiv_core #(
  parameter int W = 32,
  parameter int N = 48
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_done
);

  localparam int CW = $clog2(N + 1);

  logic [W:0]    rem_q, rem_d;
  logic [N-1:0]  dq_q, dq_d;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;

  logic [W:0]    src_rem;
  logic [N-1:0]  src_dq;
  logic [W-1:0]  src_dvs;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;
  logic          ge;

  // dq holds the unconsumed dividend bits on top and collected quotient bits below.
  always_comb begin
    src_rem = i_start ? '0 : rem_q;
    src_dq  = i_start ? i_dividend : dq_q;
    src_dvs = i_start ? i_divisor : dvs_q;
    shifted = {src_rem[W-1:0], src_dq[N-1]};
    diff    = {1'b0, shifted} - {2'b00, src_dvs};
    ge      = ~diff[W+1];
    rem_d   = ge ? diff[W:0] : shifted;
    dq_d    = {src_dq[N-2:0], ge};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rem_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_start) begin
        rem_q  <= rem_d;
        dq_q   <= dq_d;
        dvs_q  <= i_divisor;
        cnt_q  <= CW'(N - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = dq_q;
  assign o_done     = done_q;

endmodule

// File: rtl/fip_seq_div.sv
// Signed fixed-point divider: valid/ready front end, sign handling and result formation
// around the unsigned iterative core.
module fip_seq_div
  import fip_pkg::*;
#(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16,
  parameter int SATURATE  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_dividend,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_divisor,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] o_quotient,
  output logic                          o_overflow,
  output logic                          o_div_zero,
  output fip_div_state_t                o_state
);

  localparam int W = INT_BITS + FRAC_BITS;
  localparam int N = W + FRAC_BITS;
  localparam logic [63:0] MAX64 = fip_max(W);
  localparam logic [63:0] MIN64 = fip_min(W);
  localparam logic [W-1:0] MAX_W = MAX64[W-1:0];
  localparam logic [W-1:0] MIN_W = MIN64[W-1:0];

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // the producer holds its data while valid is high and ready is low.
  fip_div_state_t state_q;
  logic           neg_q, valid_q, ovf_q, dz_q;
  logic [W-1:0]   quot_q;

  logic [W-1:0] mag_a, mag_b, q_lo, signed_q, res_c, dz_res;
  logic         core_start, core_done, ovf_pos, ovf_neg, ovf_c;
  logic [N-1:0] core_q;

  always_comb begin
    mag_a      = i_dividend[W-1] ? (W'(0) - i_dividend) : i_dividend;
    mag_b      = i_divisor[W-1] ? (W'(0) - i_divisor) : i_divisor;
    core_start = (state_q == IDLE) && i_valid && (i_divisor != '0);
    dz_res     = (SATURATE != 0) ? (i_dividend[W-1] ? MIN_W : MAX_W) : '0;
    // A negative result may reach one step further than a positive one.
    q_lo       = core_q[W-1:0];
    ovf_pos    = |core_q[N-1:W-1];
    ovf_neg    = (|core_q[N-1:W]) || (core_q[W-1] && (|core_q[W-2:0]));
    ovf_c      = neg_q ? ovf_neg : ovf_pos;
    signed_q   = neg_q ? (W'(0) - q_lo) : q_lo;
    res_c      = (ovf_c && (SATURATE != 0)) ? (neg_q ? MIN_W : MAX_W) : signed_q;
  end

  fip_udiv_core #(.W(W), .N(N)) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (core_start),
    .i_dividend ({mag_a, {FRAC_BITS{1'b0}}}),
    .i_divisor  (mag_b),
    .o_quotient (core_q),
    .o_done     (core_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          neg_q <= i_dividend[W-1] ^ i_divisor[W-1];
          if (i_divisor == '0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b1;
            quot_q  <= dz_res;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: if (core_done) begin
          state_q <= DONE;
          valid_q <= 1'b1;
          ovf_q   <= ovf_c;
          dz_q    <= 1'b0;
          quot_q  <= res_c;
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE) && !i_reset;
  assign o_valid    = valid_q;
  assign o_quotient = quot_q;
  assign o_overflow = ovf_q;
  assign o_div_zero = dz_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_fip_seq_div.sv
// Bench for fip_seq_div (Q16.16): saturating and wrapping instances share stimulus;
// a queue-based scoreboard compares both against an arithmetic reference model.
module tb_fip_seq_div;
  import fip_pkg::*;

  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;

  logic        o_ready_s, o_valid_s, o_ovf_s, o_dz_s;
  logic        o_ready_w, o_valid_w, o_ovf_w, o_dz_w;
  logic [31:0] o_quot_s, o_quot_w;
  fip_div_state_t st_s, st_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rdy_mode = 1'b0;
  bit rdy_force = 1'b1;
  bit pres = 1'b0;
  bit hs_prev = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [1:0]  exp_flag_q[$];
  int          exp_cyc_q[$];

  fip_seq_div #(.INT_BITS(16), .FRAC_BITS(16), .SATURATE(1)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid_s), .i_ready(i_ready),
    .o_quotient(o_quot_s), .o_overflow(o_ovf_s), .o_div_zero(o_dz_s), .o_state(st_s)
  );

  fip_seq_div #(.INT_BITS(16), .FRAC_BITS(16), .SATURATE(0)) dut_wrap (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready_w),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid_w), .i_ready(i_ready),
    .o_quotient(o_quot_w), .o_overflow(o_ovf_w), .o_div_zero(o_dz_w), .o_state(st_w)
  );

  // Clock / reset-independent housekeeping
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #2;
    i_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact rational quotient truncated toward zero, then range-checked.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q_sat, output logic [31:0] q_wrap,
                                  output logic ovf, output logic dz);
    longint sa, sb, ma, mb, mag, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      dz = 1'b1;
      ovf = 1'b0;
      q_sat = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      q_wrap = 32'h0;
    end else begin
      dz = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      mag = (ma * 65536) / mb;
      res = ((sa < 0) != (sb < 0)) ? -mag : mag;
      ovf = (res > QMAX) || (res < QMIN);
      q_wrap = res[31:0];
      q_sat = ovf ? ((res > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : res[31:0];
    end
  endfunction

  // Driver: present operands, wait for acceptance, push the expected response.
  task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
    int guard;
    logic [31:0] qs, qw;
    logic ovf, dz;
    guard = 0;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_dividend = a;
    i_divisor = b;
    @(negedge i_clk);
    while (!o_ready_s && guard < 300) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready_s) begin
      chk("accept_timeout", {63'd0, o_ready_s}, 64'd1);
      acc = -1;
    end else begin
      ref_div(a, b, qs, qw, ovf, dz);
      exp_q.push_back(qs);
      exp_w_q.push_back(qw);
      exp_flag_q.push_back({ovf, dz});
      exp_cyc_q.push_back(cyc + (dz ? 1 : 49));
      acc = cyc;
    end
  endtask

  task automatic idle(input int n);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_dividend = $urandom;
    i_divisor = $urandom;
    repeat (n) begin
      @(posedge i_clk); #1;
      i_dividend = $urandom;
      i_divisor = $urandom;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || pres) && g < 1000) begin
      @(negedge i_clk);
      g++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(negedge i_clk);
  endtask

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (i_reset) begin
      pres = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("idle_after_handshake", {60'd0, o_ready_s, o_ready_w, st_s == IDLE, st_w == IDLE}, 64'hF);
        hs_prev = 1'b0;
      end
      if (o_valid_s || o_valid_w) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {62'd0, o_valid_s, o_valid_w}, 64'd0);
        end else begin
          if (!pres) begin
            chk("latency", 64'(cyc), 64'(exp_cyc_q[0]));
            pres = 1'b1;
          end
          chk("valid_both", {62'd0, o_valid_s, o_valid_w}, 64'd3);
          chk("quotient_sat", {32'd0, o_quot_s}, {32'd0, exp_q[0]});
          chk("quotient_wrap", {32'd0, o_quot_w}, {32'd0, exp_w_q[0]});
          chk("flags_sat", {62'd0, o_ovf_s, o_dz_s}, {62'd0, exp_flag_q[0]});
          chk("flags_wrap", {62'd0, o_ovf_w, o_dz_w}, {62'd0, exp_flag_q[0]});
          chk("ready_low_in_done", {62'd0, o_ready_s, o_ready_w}, 64'd0);
          if (i_ready) begin
            void'(exp_q.pop_front());
            void'(exp_w_q.pop_front());
            void'(exp_flag_q.pop_front());
            void'(exp_cyc_q.pop_front());
            pres = 1'b0;
            hs_prev = 1'b1;
          end
        end
      end else if (pres) begin
        chk("valid_dropped", {62'd0, o_valid_s, o_valid_w}, 64'd3);
        pres = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    int ca, cb, seen;
    logic [31:0] a, b;

    repeat (2) @(negedge i_clk);
    chk("reset_ready", {62'd0, o_ready_s, o_ready_w}, 64'd0);
    chk("reset_flags", {58'd0, o_valid_s, o_ovf_s, o_dz_s, o_valid_w, o_ovf_w, o_dz_w}, 64'd0);
    chk("reset_quotient", {o_quot_s, o_quot_w}, 64'd0);
    chk("reset_state", {62'd0, st_s == IDLE, st_w == IDLE}, 64'd3);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("ready_after_reset", {62'd0, o_ready_s, o_ready_w}, 64'd3);

    // Directed values, including overflow and div-by-zero boundaries
    send(32'h0006_0000, 32'h0002_0000, ca); idle(1);
    send(32'hFFF8_8000, 32'h0002_0000, ca); idle(0);
    send(32'h0001_0000, 32'h0003_0000, ca); idle(2);
    send(32'h4000_0000, 32'h0000_8000, ca); idle(0);
    send(32'h8000_0000, 32'hFFFF_0000, ca); idle(1);
    send(32'h8000_0000, 32'h0001_0000, ca); idle(0);
    send(32'h7FFF_FFFF, 32'h0001_0000, ca); idle(0);
    send(32'hFFFF_0000, 32'h0000_0000, ca); idle(1);
    send(32'h0001_0000, 32'h0000_0000, ca); idle(0);
    drain();

    // Backpressure: hold i_ready low for 5 cycles of o_valid
    rdy_force = 1'b0;
    send(32'h0006_0000, 32'h0002_0000, ca); idle(0);
    seen = 0;
    while (!o_valid_s && seen < 100) begin
      @(negedge i_clk);
      seen++;
    end
    chk("bp_valid_seen", {63'd0, o_valid_s}, 64'd1);
    repeat (5) @(posedge i_clk);
    #1 rdy_force = 1'b1;
    drain();

    // Back-to-back with i_valid held high
    send(32'h0006_0000, 32'h0002_0000, ca);
    send(32'h0001_0000, 32'h0003_0000, cb); idle(0);
    chk("b2b_spacing", 64'(cb - ca), 64'd50);
    drain();
    send(32'hFFFF_0000, 32'h0000_0000, ca);
    send(32'h0000_0000, 32'h0000_0000, cb); idle(0);
    chk("b2b_div0_spacing", 64'(cb - ca), 64'd2);
    drain();

    // Randomized traffic with random backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) != 0) b = 32'h0 - b;
      if ($urandom_range(0, 9) == 0) b = 32'h0;
      send(a, b, ca);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(0);
    drain();
    rdy_mode = 1'b0;
    rdy_force = 1'b1;

    // Reset in the middle of a divide aborts it
    send(32'h0006_0000, 32'h0002_0000, ca); idle(0);
    while (cyc < ca + 20) begin
      @(posedge i_clk); #1;
    end
    i_reset = 1'b1;
    exp_q.delete();
    exp_w_q.delete();
    exp_flag_q.delete();
    exp_cyc_q.delete();
    @(negedge i_clk);
    chk("abort_ready_in_reset", {62'd0, o_ready_s, o_ready_w}, 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge i_clk);
      if (o_valid_s || o_valid_w) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    send(32'h0006_0000, 32'h0002_0000, ca); idle(0);
    drain();

    chk("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
